zjh_decoder_138: RTL
====================

# zjh_decoder_138

Registered 3-to-8 decoder that is the receiving end of the 8-to-3 priority encoder path. It takes the encoder's active-low code and group-select and qualifies the code for a programmable number of stable cycles. It then drives one active-low output line per accepted code, in the style of a 74HC138 with 74HC148-compatible code polarity. A scan mode walks all eight lines in turn for display/keypad-column driving.

## Interface
- STABLE_CYC, 4: consecutive identical samples required to accept a code; legal range 1..15.
- SCAN_DIV, 8: cycles each line stays active in scan mode; legal range 1..255.

- clk  in  1  rising-edge clock, only clock of the block.
- rst  in  1  reset, synchronous, active-high.
- A  in  3  active-low encoded code from the encoder; decoded line index = ~A (A=3'b000 → line 7).
- GS  in  1  active-low group select; 0 = code on A is present.
- G1  in  1  active-high enable.
- G2_n  in  1  active-low enable; block enabled when G1=1 and G2_n=0.
- mode  in  1  0 = follow (decode A), 1 = scan.
- Y  out  8  active-low one-hot decoded lines, registered.
- valid  out  1  1 while Y carries an accepted code or scan slot.
- chg  out  1  one-cycle pulse whenever Y changes to a new active line.

## Operation
- Priority at every edge: rst > disable (G1=0 or G2_n=1) > mode.
- rst or disable: next state IDLE, Y=8'hFF, valid=0, chg=0, qualifier count and scan slot cleared.
- States: IDLE, QUAL, HOLD, SCAN.
- IDLE: Y=FF, valid=0. GS=0 and mode=0 → cand<=~A, cnt<=1, go QUAL. If STABLE_CYC=1, accept immediately.
- QUAL:
  - GS=1 → IDLE; Y is FF on the next cycle.
  - ~A≠cand → cand<=~A, cnt<=1, stay in QUAL.
  - Otherwise cnt++. On the edge where cnt reaches STABLE_CYC: Y<=~(8'b1<<cand), valid<=1, chg<=1, go HOLD.
  - Y and valid keep their previous values while in QUAL. Re-qualification from HOLD therefore keeps showing the old line.
- HOLD:
  - GS=1 → IDLE; Y=FF, valid=0, no chg.
  - ~A≠current line → QUAL with the new candidate; Y is held.
  - Same code → stay in HOLD, no chg.
- SCAN:
  - Entered from any state when mode=1 and enabled. slot<=0, div<=0, Y<=8'hFE, valid<=1, chg<=1.
  - div counts 0..SCAN_DIV-1. At wrap, slot<=slot+1 (7 wraps to 0), Y updated, chg pulses.
  - A and GS are ignored.
  - mode=0 → IDLE with Y=FF and valid=0; a code must be fully re-qualified.
- chg pulses only on a transition to a different active line, or on entry from FF to an active line. With SCAN_DIV=1 and the slot advancing every cycle, chg is high every cycle.
- Widths: cnt is 4 bits and saturates at STABLE_CYC. div is 8 bits. slot is 3 bits with natural wrap.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: Y=8'hFF, valid=0, chg=0.
- Follow latency: the code is first sampled at edge k and accepted at edge k+STABLE_CYC-1. Y is visible after that edge; with the default, 4 edges.
- Release latency: GS=1 sampled at edge k → Y=FF after edge k.
- Disable and rst act on the first sampling edge. A disable mid-QUAL discards the count.
- Scan: each line is active for exactly SCAN_DIV cycles; the full period is 8×SCAN_DIV cycles.
- A change of A on the same edge that completes qualification is treated as a mismatch and restarts QUAL; nothing is accepted.

## Test plan
- Reset: rst=1 for 2 cycles with A=3'b010, GS=0, enabled → Y=8'hFF, valid=0, chg=0 throughout, and for STABLE_CYC-1 edges after release.
- Follow: enabled, mode=0, A=3'b000, GS=0 held → Y=8'h7F and valid=1 after the 4th edge; chg high for exactly that one cycle.
- Glitch: A=3'b101 for 2 cycles, then 3'b110 held → line 2 never appears; Y=8'hFD after the 4th edge of 3'b110.
- Release/disable: from HOLD on line 1, GS=1 → Y=FF next cycle with no chg. In a separate run, G2_n=1 at cnt=3 in QUAL → Y stays FF, and re-enable needs 4 fresh edges.
- Scan: mode=1, SCAN_DIV=8 → Y sequence FE, FD, FB, F7, EF, DF, BF, 7F with 8 cycles each, then back to FE at cycle 64; chg pulses every 8 cycles; A/GS toggling has no effect.
- Mode switch: mode 1→0 while in slot 5 → Y=FF next cycle; a held code A=3'b100 yields Y=8'hF7 after 4 edges.

Source files
------------

// File: rtl/zjh_decoder_138.sv
// zjh_decoder_138: registered 3-to-8 decoder (active-low A/GS in, active-low one-hot Y out) with code qualification and line scan; ports clk, rst, A, GS, G1, G2_n, mode -> Y, valid, chg
module zjh_decoder_138 #(
  parameter int STABLE_CYC = 4,
  parameter int SCAN_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic       GS,
  input  logic       G1,
  input  logic       G2_n,
  input  logic       mode,
  output logic [7:0] Y,
  output logic       valid,
  output logic       chg
);
  typedef enum logic [1:0] {IDLE, QUAL, HOLD, SCAN} state_t;
  state_t r_st, w_st;
  logic [2:0] r_cand, w_cand, r_slot, w_slot, w_code;
  logic [3:0] r_cnt, w_cnt, w_n;
  logic [7:0] r_div, w_div, w_y;
  logic w_match, w_wrap;
  always_comb begin
    w_code = ~A;
    w_match = (r_st == QUAL || r_st == HOLD) && w_code == r_cand;
    w_n = (r_st == QUAL && w_match) ? r_cnt + 4'd1 : 4'd1;
    w_wrap = r_div == 8'(SCAN_DIV - 1);
    w_st = r_st;
    w_cand = r_cand;
    w_cnt = r_cnt;
    w_slot = r_slot;
    w_div = r_div;
    w_y = Y;
    if (!G1 || G2_n || (!mode && (r_st == SCAN || GS))) begin
      w_st = IDLE;
      w_cnt = 4'd0;
      w_slot = 3'd0;
      w_div = 8'd0;
      w_y = 8'hFF;
    end else if (mode) begin
      w_st = SCAN;
      w_cnt = 4'd0;
      w_div = (r_st != SCAN || w_wrap) ? 8'd0 : r_div + 8'd1;
      w_slot = r_st != SCAN ? 3'd0 : w_wrap ? r_slot + 3'd1 : r_slot;
      w_y = ~(8'b1 << w_slot);
    end else if (!(r_st == HOLD && w_match)) begin
      // a fresh or mismatching sample restarts the run at 1; the held line stays visible until acceptance
      w_cand = w_code;
      w_cnt = w_n;
      w_st = w_n >= 4'(STABLE_CYC) ? HOLD : QUAL;
      w_y = w_n >= 4'(STABLE_CYC) ? ~(8'b1 << w_code) : Y;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      r_cand <= 3'd0;
      r_cnt <= 4'd0;
      r_slot <= 3'd0;
      r_div <= 8'd0;
      Y <= 8'hFF;
      valid <= 1'b0;
      chg <= 1'b0;
    end else begin
      r_st <= w_st;
      r_cand <= w_cand;
      r_cnt <= w_cnt;
      r_slot <= w_slot;
      r_div <= w_div;
      Y <= w_y;
      valid <= w_y != 8'hFF;
      chg <= w_y != 8'hFF && w_y != Y;
    end
  end
endmodule
